// File: rtl/k_rpack_pkg.sv
// Shared types for the read-side FIFO packer k_rpack_t1.
package k_rpack_pkg;

  typedef enum logic {
    FILL       = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  function automatic int unsigned lane_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/k_rpack_t1.sv
// Drains an async FIFO read port and packs pack_n entries into one valid/ready word.
// Optional partial-word flush is enabled with macro K_RPACK_FLUSH_EN.
module k_rpack_t1
  import k_rpack_pkg::*;
#(
  parameter  int unsigned data_size = 8,
  parameter  int unsigned pack_n    = 4,
  localparam int unsigned cnt_w     = lane_w(pack_n)
) (
  input  logic                        rclk,
  input  logic                        rrst_n,
  input  logic [data_size-1:0]        rdata,
  input  logic                        rempty,
  output logic                        rget,
  output logic [data_size*pack_n-1:0] odata,
  output logic                        ovalid,
  input  logic                        oready,
  output logic [cnt_w-1:0]            ocnt
`ifdef K_RPACK_FLUSH_EN
  ,
  input  logic                        flush
`endif
);

  localparam int unsigned      W    = data_size * pack_n;
  localparam logic [cnt_w-1:0] LAST = cnt_w'(pack_n - 1);
  localparam logic [cnt_w-1:0] FULL = cnt_w'(pack_n);

  logic [W-1:0]     acc;
  logic [W-1:0]     acc_pop;
  logic [cnt_w-1:0] cnt;
  logic [cnt_w-1:0] k;
  logic [cnt_w-1:0] ld_cnt;
  state_t           state;
  logic             out_free;
  logic             last_lane;
  logic             word_load;
  logic             fl_load;
  logic             go_wait;
  logic             load;

  assign out_free  = !ovalid || oready;
  assign last_lane = (cnt == LAST);
  assign rget      = rrst_n && !rempty && (state == FILL) && !(last_lane && !out_free);
  assign k         = cnt + cnt_w'(rget);
  assign word_load = rget && last_lane;

  // Accumulator as it looks after this cycle's pop; also the full word on completion.
  always_comb begin
    acc_pop = acc;
    for (int unsigned i = 0; i < pack_n; i++) begin
      if (rget && (cnt == cnt_w'(i))) acc_pop[i*data_size +: data_size] = rdata;
    end
  end

`ifdef K_RPACK_FLUSH_EN
  logic flush_fill;

  // In FLUSH_WAIT no pop happens, so k equals the held lane count.
  assign flush_fill = (state == FILL) && flush && !word_load && (k != '0);
  assign fl_load    = out_free && (flush_fill || (state == FLUSH_WAIT));
  assign go_wait    = flush_fill && !out_free;
  assign ld_cnt     = word_load ? FULL : k;
`else
  assign state   = FILL;
  assign fl_load = 1'b0;
  assign go_wait = 1'b0;
  assign ld_cnt  = FULL;
`endif

  assign load = word_load || fl_load;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      ovalid <= 1'b0;
      odata  <= '0;
      ocnt   <= '0;
      cnt    <= '0;
      acc    <= '0;
`ifdef K_RPACK_FLUSH_EN
      state  <= FILL;
`endif
    end else begin
      if (load) begin
        odata  <= acc_pop;
        ocnt   <= ld_cnt;
        ovalid <= 1'b1;
        cnt    <= '0;
        acc    <= '0;
      end else begin
        if (ovalid && oready) ovalid <= 1'b0;
        if (rget) begin
          acc <= acc_pop;
          cnt <= k;
        end
      end
`ifdef K_RPACK_FLUSH_EN
      if (fl_load)      state <= FILL;
      else if (go_wait) state <= FLUSH_WAIT;
`endif
    end
  end

endmodule

// File: tb/tb_k_rpack_t1.sv
// Directed scoreboard bench for k_rpack_t1 (pack_n=4, data_size=8).
module tb_k_rpack_t1;

  localparam int DS = 8;
  localparam int PN = 4;
  localparam int CW = 3;

  logic          rclk   = 1'b0;
  logic          rrst_n = 1'b0;
  logic [DS-1:0] rdata  = '0;
  logic          rempty = 1'b1;
  logic          rget;
  logic [DS*PN-1:0] odata;
  logic          ovalid;
  logic          oready = 1'b0;
  logic [CW-1:0] ocnt;
`ifdef K_RPACK_FLUSH_EN
  logic          flush  = 1'b0;
`endif

  always #5 rclk = ~rclk;

  k_rpack_t1 #(.data_size(DS), .pack_n(PN)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rdata  (rdata),
    .rempty (rempty),
    .rget   (rget),
    .odata  (odata),
    .ovalid (ovalid),
    .oready (oready),
    .ocnt   (ocnt)
`ifdef K_RPACK_FLUSH_EN
    ,
    .flush  (flush)
`endif
  );

  typedef struct {
    logic [DS*PN-1:0] d;
    logic [CW-1:0]    c;
  } exp_t;

  logic [DS-1:0] fifo[$];
  logic [DS-1:0] part[$];
  exp_t          exp_q[$];

  int tests = 0;
  int fails = 0;

  logic          gap_en = 1'b0;
  logic          gap    = 1'b0;
  logic          last_rget = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DS*PN-1:0] prev_d = '0;
  logic [CW-1:0] prev_c = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    rempty = (fifo.size() == 0) || gap;
    rdata  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic push_exp(input int n);
    exp_t e;
    e.d = '0;
    for (int i = 0; i < n; i++) e.d[i*DS +: DS] = part[i];
    e.c = CW'(n);
    exp_q.push_back(e);
    part.delete();
  endtask

  task automatic push(input logic [DS-1:0] v);
    fifo.push_back(v);
    part.push_back(v);
    if (part.size() == PN) push_exp(PN);
    present();
  endtask

  task automatic flush_exp();
    if (part.size() != 0) push_exp(part.size());
  endtask

  // One rclk cycle: sample/check at negedge, apply FIFO pop after posedge.
  task automatic cycle();
    exp_t e;
    @(negedge rclk);
    last_rget = rget;
    if (rempty) chk("rget_on_empty", 64'(rget), 64'd0);
    if (prev_stall) begin
      chk("hold_valid", 64'(ovalid), 64'd1);
      chk("hold_data", 64'(odata), 64'(prev_d));
      chk("hold_cnt", 64'(ocnt), 64'(prev_c));
    end
    if (ovalid && oready && rrst_n) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 64'(odata), 64'(e.d));
        chk("word_cnt", 64'(ocnt), 64'(e.c));
      end
    end
    prev_stall = ovalid && !oready && rrst_n;
    prev_d     = odata;
    prev_c     = ocnt;
    @(posedge rclk);
    if (last_rget) void'(fifo.pop_front());
    #1;
    gap = gap_en ? ~gap : 1'b0;
    present();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || ovalid); i++) cycle();
    chk("drain_done", 64'(exp_q.size()) + 64'(ovalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset state and first word latency.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    cycle(); cycle();
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_odata", 64'(odata), 64'd0);
    chk("rst_ocnt", 64'(ocnt), 64'd0);
    chk("rst_rget", 64'(rget), 64'd0);
    rrst_n = 1'b1;
    oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_rget", 64'(last_rget), 64'd1);
      if (i == 2) chk("t1_early_valid", 64'(ovalid), 64'd0);
    end
    chk("t1_ovalid", 64'(ovalid), 64'd1);
    chk("t1_odata", 64'(odata), 64'h44332211);
    chk("t1_ocnt", 64'(ocnt), 64'd4);

    // Test 2: sustained streaming, no rget bubble.
    for (int v = 1; v <= 8; v++) push(8'(v));
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t2_rget", 64'(last_rget), 64'd1);
    end
    drain();

    // Test 3: backpressure holds word, stalls last lane.
    oready = 1'b0;
    for (int v = 1; v <= 8; v++) push(8'(v));
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("t3_rget", 64'(last_rget), 64'd1);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t3_stall_rget", 64'(last_rget), 64'd0);
    end
    chk("t3_held_data", 64'(odata), 64'h04030201);
    oready = 1'b1;
    cycle();
    chk("t3_resume_rget", 64'(last_rget), 64'd1);
    chk("t3_next_valid", 64'(ovalid), 64'd1);
    chk("t3_next_data", 64'(odata), 64'h08070605);
    drain();

    // Test 4: gapped FIFO with random backpressure.
    gap_en = 1'b1;
    for (int v = 0; v < 12; v++) push(8'h10 + 8'(v));
    for (int i = 0; i < 30; i++) begin
      oready = 1'($urandom_range(0, 1));
      cycle();
    end
    oready = 1'b1;
    drain();
    gap_en = 1'b0;
    gap    = 1'b0;
    present();

`ifdef K_RPACK_FLUSH_EN
    // Flush with no buffered lanes produces nothing.
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("f0_no_word", 64'(ovalid), 64'd0);
    end

    // Partial word flush with free output.
    push(8'hAA); push(8'hBB);
    cycle(); cycle();
    flush = 1'b1;
    flush_exp();
    cycle();
    flush = 1'b0;
    chk("f1_ovalid", 64'(ovalid), 64'd1);
    chk("f1_odata", 64'(odata), 64'h0000BBAA);
    chk("f1_ocnt", 64'(ocnt), 64'd2);
    drain();

    // Flush while output busy waits, blocking pops.
    oready = 1'b0;
    for (int v = 1; v <= 6; v++) push(8'hC0 + 8'(v));
    for (int i = 0; i < 6; i++) cycle();
    flush = 1'b1;
    flush_exp();
    cycle();
    flush = 1'b0;
    push(8'hC7);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("f2_wait_rget", 64'(last_rget), 64'd0);
    end
    oready = 1'b1;
    cycle();
    chk("f2_accept_rget", 64'(last_rget), 64'd0);
    chk("f2_odata", 64'(odata), 64'h0000C6C5);
    chk("f2_ocnt", 64'(ocnt), 64'd2);
    cycle();
    chk("f2_resume_rget", 64'(last_rget), 64'd1);
    flush = 1'b1;
    flush_exp();
    cycle();
    flush = 1'b0;
    drain();
`endif

    // Test 6: reset mid-word discards partial and pending word.
    oready = 1'b0;
    for (int v = 1; v <= 6; v++) push(8'h20 + 8'(v));
    for (int i = 0; i < 6; i++) cycle();
    chk("t6_pre_valid", 64'(ovalid), 64'd1);
    rrst_n = 1'b0;
    exp_q.delete();
    part.delete();
    cycle();
    chk("t6_rst_valid", 64'(ovalid), 64'd0);
    chk("t6_rst_ocnt", 64'(ocnt), 64'd0);
    rrst_n = 1'b1;
    oready = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    for (int i = 0; i < 4; i++) cycle();
    chk("t6_clean_data", 64'(odata), 64'hA4A3A2A1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
